// File: rtl/move_request.sv
// Debounced, latched move requests (left/right/rotate) for the game controller.
// Optional left/right auto-repeat is compiled in when MOVE_REQUEST_AUTOREPEAT_EN is defined.
module move_request #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_left,
    input  logic key_right,
    input  logic key_rotate,
    input  logic consume,
    output logic left,
    output logic right,
    output logic rotate,
    output logic pending
);

    localparam int KEYS = 3;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("move_request: DEBOUNCE_CYCLES must be >= 2, repeat periods >= 1");
    end

    // Bit order everywhere: [0]=left, [1]=right, [2]=rotate.
    logic [KEYS-1:0] raw;
    logic [KEYS-1:0] sync_a;
    logic [KEYS-1:0] sync_b;
    logic [KEYS-1:0] deb;
    logic [KEYS-1:0] deb_prev;
    logic [KEYS-1:0] rise;
    logic [KEYS-1:0] set;
    logic [KEYS-1:0] req;
    logic [DB_W-1:0] db_cnt [KEYS];

    assign raw = {key_rotate, key_right, key_left};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // The counter only survives while the synchronized key keeps disagreeing with the debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int k = 0; k < KEYS; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int k = 0; k < KEYS; k++) begin
                if (sync_b[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    deb[k]    <= sync_b[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign rise = deb & ~deb_prev;

`ifdef MOVE_REQUEST_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]       rpt_state [2];
    logic [RPT_W-1:0] rpt_cnt   [2];
    logic [1:0]       rpt_set;
    logic             both_held;

    // Holding both directions cancels repeat entirely so the piece does not jitter.
    assign both_held = deb[0] & deb[1];

    always_comb begin
        rpt_set = '0;
        for (int k = 0; k < 2; k++) begin
            if (deb[k] && !both_held) begin
                if (rpt_state[k] == ST_DELAY && rpt_cnt[k] == DELAY_LAST) begin
                    rpt_set[k] = 1'b1;
                end else if (rpt_state[k] == ST_REPEAT && rpt_cnt[k] == RATE_LAST) begin
                    rpt_set[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                rpt_state[k] <= ST_IDLE;
                rpt_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (rpt_state[k])
                    ST_IDLE: begin
                        rpt_cnt[k] <= '0;
                        if (rise[k] && !both_held) begin
                            rpt_state[k] <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (!deb[k] || both_held) begin
                            rpt_state[k] <= ST_IDLE;
                            rpt_cnt[k]   <= '0;
                        end else if (rpt_cnt[k] == DELAY_LAST) begin
                            rpt_state[k] <= ST_REPEAT;
                            rpt_cnt[k]   <= '0;
                        end else begin
                            rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!deb[k] || both_held) begin
                            rpt_state[k] <= ST_IDLE;
                            rpt_cnt[k]   <= '0;
                        end else if (rpt_cnt[k] == RATE_LAST) begin
                            rpt_cnt[k] <= '0;
                        end else begin
                            rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_state[k] <= ST_IDLE;
                        rpt_cnt[k]   <= '0;
                    end
                endcase
            end
        end
    end

    assign set = rise | {1'b0, rpt_set};
`else
    assign set = rise;
`endif

    // A new set beats a coincident consume so that press is never dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req <= '0;
        end else begin
            req <= set | (req & {KEYS{~consume}});
        end
    end

    assign left    = req[0];
    assign right   = req[1];
    assign rotate  = req[2];
    assign pending = |req;

endmodule

// File: tb/tb_move_request.sv
// Self-checking bench for move_request with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5.
// Cycle c is sampled 1 time unit after the c-th rising edge following the test origin.
module tb_move_request;

`ifdef MOVE_REQUEST_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic reset_n;
    logic key_left;
    logic key_right;
    logic key_rotate;
    logic consume;
    logic left;
    logic right;
    logic rotate;
    logic pending;

    int checks;
    int failures;
    logic [3:0] exp_q [$];

    move_request #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_left(key_left),
        .key_right(key_right),
        .key_rotate(key_rotate),
        .consume(consume),
        .left(left),
        .right(right),
        .rotate(rotate),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector {pending, rotate, right, left}; pending is the OR of the three requests.
    function automatic logic [3:0] vec(input logic l, input logic r, input logic ro);
        return {l | r | ro, ro, r, l};
    endfunction

    // Cycles in which a right request must be visible while right is held and consumed each time.
    function automatic bit right_req_cycle(input int c);
        if (c == 7) return 1'b1;
        if (AUTO && (c == 17 || c == 22 || c == 27 || c == 32)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus_start();
        reset_n    = 1'b0;
        key_left   = 1'b0;
        key_right  = 1'b0;
        key_rotate = 1'b0;
        consume    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        logic [3:0] got;
        reset_n    = 1'b0;
        key_left   = 1'b1;
        key_right  = 1'b0;
        key_rotate = 1'b1;
        consume    = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", c, got, exp);
            end
        end
        reset_n = 1'b1;
        exp = vec(1'b0, 1'b0, 1'b0);
        got = {pending, rotate, right, left};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL reset_release cycle 0: got %b expected %b", got, exp);
        end
        for (int c = 0; c < 12; c++) begin
            exp_q.push_back(vec(c + 1 >= 7, 1'b0, c + 1 >= 7));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL reset_held_key cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_press_hold();
        logic [3:0] exp;
        logic [3:0] got;
        applyStimulus_start();
        for (int c = 0; c < 25; c++) begin
            key_left = 1'b1;
            exp_q.push_back(vec(c + 1 >= 7, 1'b0, 1'b0));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL press_hold cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        logic [3:0] got;
        applyStimulus_start();
        for (int c = 0; c < 40; c++) begin
            key_rotate = (c <= 2) || (c >= 20 && c <= 25);
            consume    = (c == 29);
            exp_q.push_back(vec(1'b0, 1'b0, (c + 1 >= 27) && (c + 1 < 30)));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL glitch_rotate cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
        consume = 1'b0;
    endtask

    task automatic test_consume_collision();
        logic [3:0] exp;
        logic [3:0] got;
        applyStimulus_start();
        for (int c = 0; c < 20; c++) begin
            key_rotate = (c <= 9);
            key_left   = (c >= 3);
            consume    = (c == 9);
            exp_q.push_back(vec(c + 1 >= 10, 1'b0, (c + 1 >= 7) && (c + 1 < 10)));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL consume_collision cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
        consume = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp;
        logic [3:0] got;
        logic       both;
        applyStimulus_start();
        for (int c = 0; c < 40; c++) begin
            key_left  = (c < 25);
            key_right = (c < 25);
            consume   = (c == 12);
            both      = (c + 1 >= 7) && (c + 1 < 13);
            exp_q.push_back(vec(both, both, 1'b0));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL simultaneous cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
        consume = 1'b0;
    endtask

    task automatic test_autorepeat();
        logic [3:0] exp;
        logic [3:0] got;
        applyStimulus_start();
        for (int c = 0; c < 50; c++) begin
            key_right = (c < 30);
            consume   = right_req_cycle(c);
            exp_q.push_back(vec(1'b0, right_req_cycle(c + 1), 1'b0));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL autorepeat cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
        consume = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        logic [3:0] got;
        applyStimulus_start();
        for (int c = 0; c < 22; c++) begin
            key_left = 1'b1;
            reset_n  = !(c >= 5 && c < 8);
            got = {pending, rotate, right, left};
            if (!reset_n) begin
                checks++;
                if (got !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL reset_mid_async cycle %0d: got %b expected %b", c, got, 4'b0000);
                end
            end
            exp_q.push_back(vec(c + 1 >= 15, 1'b0, 1'b0));
            tick();
            exp = exp_q.pop_front();
            got = {pending, rotate, right, left};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL reset_mid cycle %0d: got %b expected %b", c + 1, got, exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        key_left   = 1'b0;
        key_right  = 1'b0;
        key_rotate = 1'b0;
        consume    = 1'b0;
        repeat (2) tick();
        test_reset();
        test_press_hold();
        test_glitch();
        test_consume_collision();
        test_simultaneous();
        test_autorepeat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
